turf_command_transmitter: RTL and testbench

Serializes one trigger command per request onto the single-wire SURF command line at 1/8th of the 33 MHz clock rate. It is the transmit-side stage directly upstream of the SURF command receiver. Each frame carries a start bit, a 2-bit buffer number, a 32-bit event ID and a commit (stop) bit. Guard and post-reset quiet periods keep the receiver's frame alignment intact.

---
 rtl/turf_command_transmitter.sv | 148 ++++++++++++++
 tb/tb_turf_command_transmitter.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/turf_command_transmitter.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | turf_command_transmitter: serializes start/buffer/event-ID/stop frames      |
// | onto the single-wire SURF command line, with guard and post-reset quiet.    |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
module turf_command_transmitter #(
  parameter int NCLOCK_BITS = 3,
  parameter int NGUARD_BITS = 2
) (
  input  logic        clk33_i,
  input  logic        rst_i,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic [1:0]  buffer_i,
  input  logic [31:0] event_id_i,
  output logic        cmd_o,
  output logic        busy_o,
  output logic        sent_o
);

  localparam int QUIET_CLKS = (36 + NGUARD_BITS) << NCLOCK_BITS;
  localparam int QW         = $clog2(QUIET_CLKS);

  typedef enum logic [2:0] {
    QUIET = 3'd0,
    IDLE  = 3'd1,
    START = 3'd2,
    DATA  = 3'd3,
    STOP  = 3'd4,
    GUARD = 3'd5
  } state_t;

  state_t                 state_q, state_d;
  logic [NCLOCK_BITS-1:0] div_q, div_d;
  logic [5:0]             bit_q, bit_d;
  logic [QW-1:0]          quiet_q, quiet_d;
  logic [34:0]            shift_q, shift_d;
  logic                   cmd_q, cmd_d;
  logic                   ready_q, ready_d;
  logic                   sent_q, sent_d;

  logic                   accept;
  logic [NCLOCK_BITS:0]   div_inc;
  logic                   bit_end;

  always_comb begin
    accept  = cmd_valid_i & ready_q;
    div_inc = {1'b0, div_q} + 1'b1;
    bit_end = div_inc[NCLOCK_BITS];

    state_d = state_q;
    div_d   = div_inc[NCLOCK_BITS-1:0];
    bit_d   = bit_q;
    quiet_d = quiet_q;
    shift_d = shift_q;

    case (state_q)
      QUIET: begin
        div_d = '0;
        if (quiet_q == QW'(QUIET_CLKS - 1)) begin
          state_d = IDLE;
          quiet_d = '0;
        end else begin
          quiet_d = quiet_q + 1'b1;
        end
      end
      IDLE: begin
        div_d = '0;
        bit_d = '0;
        if (accept) begin
          state_d = START;
          // start bit sits in the LSB so the line simply follows shift_q[0]
          shift_d = {event_id_i, buffer_i, 1'b1};
        end
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          shift_d = shift_q >> 1;
          bit_d   = '0;
        end
      end
      DATA: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          if (bit_q == 6'd33) begin
            state_d = STOP;
            bit_d   = '0;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      STOP: begin
        if (bit_end) begin
          state_d = GUARD;
          bit_d   = '0;
        end
      end
      GUARD: begin
        if (bit_end) begin
          if (bit_q == 6'(NGUARD_BITS - 1)) begin
            state_d = IDLE;
            bit_d   = '0;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      default: state_d = QUIET;
    endcase

    cmd_d   = ((state_q == START) || (state_q == DATA)) & shift_q[0];
    sent_d  = (state_q == STOP) & bit_end;
    ready_d = (state_q == IDLE) & ~accept;
  end

  // Async reset kills cmd_o at once so a truncated frame cannot leave the line high
  always_ff @(posedge clk33_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= QUIET;
      div_q   <= '0;
      bit_q   <= '0;
      quiet_q <= '0;
      shift_q <= '0;
      cmd_q   <= 1'b0;
      ready_q <= 1'b0;
      sent_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      quiet_q <= quiet_d;
      shift_q <= shift_d;
      cmd_q   <= cmd_d;
      ready_q <= ready_d;
      sent_q  <= sent_d;
    end
  end

  assign cmd_o       = cmd_q;
  assign cmd_ready_o = ready_q;
  assign sent_o      = sent_q;
  assign busy_o      = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_turf_command_transmitter.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | tb_turf_command_transmitter: timeline model, frame decoder and directed     |
// | vectors for the SURF command transmitter.                                   |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
module tb_turf_command_transmitter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic [1:0]  buf_in = 2'd0;
  logic [31:0] id_in = 32'd0;
  logic        cmd_ready, cmd_line, busy, sent;

  turf_command_transmitter #(.NCLOCK_BITS(3), .NGUARD_BITS(2)) dut (
    .clk33_i     (clk),
    .rst_i       (rst),
    .cmd_valid_i (cmd_valid),
    .cmd_ready_o (cmd_ready),
    .buffer_i    (buf_in),
    .event_id_i  (id_in),
    .cmd_o       (cmd_line),
    .busy_o      (busy),
    .sent_o      (sent)
  );

  always #5 clk = ~clk;

  int compared = 0;
  int mismatched = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Timeline model: n counts rising edges since reset release; a frame accepted
  // at edge t_acc shows bit (d-1)/8 after edge t_acc+d, ready returns 305 later.
  int          n = 0;
  int          t_acc = -1000;
  int          ready_from = 305;
  bit          m_ready = 1'b0;
  int          acc_count = 0;
  int          acc_t[$];
  logic [35:0] frame = '0;
  logic [33:0] exp_q[$];

  always @(posedge clk) begin
    if (rst) begin
      n = 0;
      t_acc = -1000;
      ready_from = 305;
      m_ready = 1'b0;
      exp_q.delete();
    end else begin
      n++;
      if (m_ready && cmd_valid) begin
        t_acc = n;
        frame = {1'b0, id_in, buf_in, 1'b1};
        ready_from = n + 305;
        acc_count++;
        acc_t.push_back(n);
        exp_q.push_back({buf_in, id_in});
      end
      m_ready = (n >= ready_from);
    end
  end

  int   cmp_d;
  logic cmp_cmd;
  always @(negedge clk) begin
    if (rst) begin
      check("rst_cmd", cmd_line, 0);
      check("rst_ready", cmd_ready, 0);
      check("rst_sent", sent, 0);
      check("rst_busy", busy, 1);
    end else begin
      cmp_d = n - t_acc;
      cmp_cmd = (cmp_d >= 1 && cmp_d <= 288) ? frame[(cmp_d - 1) / 8] : 1'b0;
      check("cmd", cmd_line, cmp_cmd);
      check("ready", cmd_ready, m_ready);
      check("sent", sent, (cmp_d == 288));
      check("busy", busy, (n < ready_from - 1));
    end
  end

  // Mid-bit sampling receiver standing in for the SURF command decoder
  bit          dec_active = 1'b0;
  int          dec_cnt = 0;
  int          dec_frames = 0;
  logic [35:0] dec_bits = '0;
  logic [33:0] dec_exp;
  always @(negedge clk) begin
    if (rst) begin
      dec_active = 1'b0;
    end else begin
      if (!dec_active && cmd_line === 1'b1) begin
        dec_active = 1'b1;
        dec_cnt = 0;
      end
      if (dec_active) begin
        if (dec_cnt % 8 == 4) dec_bits[dec_cnt / 8] = cmd_line;
        if (dec_cnt == 8 * 35 + 4) begin
          dec_active = 1'b0;
          dec_frames++;
          check("dec_start", dec_bits[0], 1);
          check("dec_stop", dec_bits[35], 0);
          check("dec_pending", (exp_q.size() != 0), 1);
          if (exp_q.size() != 0) begin
            dec_exp = exp_q.pop_front();
            check("dec_buffer", dec_bits[2:1], dec_exp[33:32]);
            check("dec_event_id", dec_bits[34:3], dec_exp[31:0]);
          end
        end
        dec_cnt++;
      end
    end
  end

  task automatic wait_acc(input int k);
    for (int i = 0; i < 3000 && acc_count < k; i++) @(negedge clk);
    check("accept_seen", acc_count, k);
  endtask

  int cur_d;
  task automatic goto_d(input int d);
    repeat (d - cur_d) @(negedge clk);
    cur_d = d;
  endtask

  initial begin
    // Reset held for 5 clocks, then quiet period
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("reset_busy", busy, 1);
    check("reset_cmd", cmd_line, 0);
    #2 rst = 1'b0;
    cmd_valid = 1'b0;
    @(negedge clk);
    repeat (303) @(negedge clk);
    check("quiet_ready_304", cmd_ready, 0);
    check("quiet_cmd_304", cmd_line, 0);
    @(negedge clk);
    check("quiet_ready_305", cmd_ready, 1);

    // Single frame, inputs scrambled while busy
    #1 buf_in = 2'b10; id_in = 32'hA5C3_0F01; cmd_valid = 1'b1;
    wait_acc(1);
    check("first_accept_edge", acc_t[0], 306);
    #1 cmd_valid = 1'b0; buf_in = 2'b01; id_in = 32'hFFFF_FFFF;
    cur_d = 0;
    goto_d(4);   check("lit_start", cmd_line, 1);
    goto_d(12);  check("lit_buf0", cmd_line, 0);
    goto_d(20);  check("lit_buf1", cmd_line, 1);
    goto_d(28);  check("lit_id0", cmd_line, 1);
    goto_d(36);  check("lit_id1", cmd_line, 0);
    goto_d(276); check("lit_id31", cmd_line, 1);
    goto_d(284); check("lit_stop", cmd_line, 0);
    goto_d(287); check("lit_sent_early", sent, 0);
    goto_d(288); check("lit_sent", sent, 1);
    goto_d(304); check("lit_ready_304", cmd_ready, 0);
                 check("lit_idle_busy", busy, 0);
    goto_d(305); check("lit_ready_305", cmd_ready, 1);

    // Back-to-back requests with valid held high
    #1 cmd_valid = 1'b1; id_in = 32'd1; buf_in = 2'd0;
    wait_acc(2);
    #1 id_in = 32'd2; buf_in = 2'd1;
    wait_acc(3);
    #1 id_in = 32'd3; buf_in = 2'd3;
    wait_acc(4);
    #1 cmd_valid = 1'b0;
    check("b2b_gap_0", acc_t[1] - acc_t[0], 306);
    check("b2b_gap_1", acc_t[2] - acc_t[1], 306);
    check("b2b_gap_2", acc_t[3] - acc_t[2], 306);
    for (int i = 0; i < 400 && !m_ready; i++) @(negedge clk);
    check("b2b_drain", m_ready, 1);

    // Reset mid-frame while a 1 is on the line
    #1 cmd_valid = 1'b1; id_in = 32'hDEAD_BEEF; buf_in = 2'd1;
    wait_acc(5);
    #1 cmd_valid = 1'b0;
    repeat (149) @(negedge clk);
    @(posedge clk);
    #1 check("pre_rst_cmd", cmd_line, 1);
    rst = 1'b1;
    #1 check("rst_cmd_immediate", cmd_line, 0);
    check("rst_busy_immediate", busy, 1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    #2 rst = 1'b0;
    #1 cmd_valid = 1'b1; id_in = 32'h1234_5678; buf_in = 2'd2;
    wait_acc(6);
    check("post_rst_accept_edge", acc_t[5], 306);
    #1 cmd_valid = 1'b0;
    repeat (310) @(negedge clk);
    check("decoded_frames", dec_frames, 5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire
